// File: rtl/load_store_unit.sv
// MEM-stage load/store initiator: word-wide memory requests, sub-word read-modify-write stores,
// lane extraction with sign/zero extension for loads, and misaligned/illegal access rejection.
module load_store_unit #(
    parameter int unsigned ADDR_LENGTH = 32,
    parameter int unsigned DATA_LENGTH = 32,
    parameter int unsigned WORD_ADDR_W = 30
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_req,
    output logic                   o_ready,
    input  logic                   i_we,
    input  logic                   i_re,
    input  logic [4:0]             i_size_control,
    input  logic [ADDR_LENGTH-1:0] i_addr,
    input  logic [DATA_LENGTH-1:0] i_wdata,
    output logic                   o_valid,
    output logic [DATA_LENGTH-1:0] o_rdata,
    output logic                   o_misaligned,
    output logic [WORD_ADDR_W-1:0] o_mem_addr,
    output logic                   o_mem_re,
    output logic                   o_mem_we,
    output logic [4:0]             o_mem_size,
    output logic [DATA_LENGTH-1:0] o_mem_wdata,
    input  logic [DATA_LENGTH-1:0] i_mem_rdata
);

    localparam logic [1:0] SZ_B = 2'b01;
    localparam logic [1:0] SZ_H = 2'b10;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        CAP  = 3'd2,
        WR   = 3'd3,
        DONE = 3'd4,
        ERR  = 3'd5
    } state_t;

    state_t state, state_n;

    logic        op_store;
    logic [1:0]  size_q;
    logic        signed_q;
    logic [1:0]  lane_q;
    logic [15:0] store_lo;

    logic        accept_c;
    logic        is_store_c;
    logic        is_load_c;
    logic        illegal_c;
    logic [1:0]  in_size_c;
    logic        mis_c;
    logic [7:0]  lane_byte_c;
    logic [15:0] lane_half_c;
    logic [DATA_LENGTH-1:0] load_ext_c;
    logic [DATA_LENGTH-1:0] merged_c;

    assign o_mem_size = 5'b0;

    // Request decode and alignment check on the live inputs at accept time
    always_comb begin
        accept_c   = i_req && (state == IDLE);
        is_store_c = i_we && !i_re;
        is_load_c  = i_re && !i_we;
        illegal_c  = i_we && i_re;
        in_size_c  = is_store_c ? i_size_control[1:0] : i_size_control[4:3];
        mis_c      = 1'b0;
        if (is_store_c || is_load_c) begin
            if (in_size_c == SZ_H)
                mis_c = i_addr[0];
            else if (in_size_c != SZ_B)
                mis_c = (i_addr[1:0] != 2'b00);
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            state <= IDLE;
        else
            state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE: begin
                if (accept_c) begin
                    if (illegal_c || mis_c)
                        state_n = ERR;
                    else if (is_load_c)
                        state_n = RD;
                    else if (is_store_c)
                        state_n = (in_size_c == SZ_B || in_size_c == SZ_H) ? RD : WR;
                    else
                        state_n = DONE;
                end
            end
            RD:      state_n = CAP;
            CAP:     state_n = op_store ? WR : DONE;
            WR:      state_n = DONE;
            DONE:    state_n = IDLE;
            ERR:     state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Little-endian lane selection and extension of the returned memory word
    always_comb begin
        case (lane_q)
            2'd0:    lane_byte_c = i_mem_rdata[7:0];
            2'd1:    lane_byte_c = i_mem_rdata[15:8];
            2'd2:    lane_byte_c = i_mem_rdata[23:16];
            default: lane_byte_c = i_mem_rdata[31:24];
        endcase
        lane_half_c = lane_q[1] ? i_mem_rdata[31:16] : i_mem_rdata[15:0];
        case (size_q)
            SZ_B:    load_ext_c = signed_q ? {{24{lane_byte_c[7]}}, lane_byte_c}
                                           : {24'h0, lane_byte_c};
            SZ_H:    load_ext_c = signed_q ? {{16{lane_half_c[15]}}, lane_half_c}
                                           : {16'h0, lane_half_c};
            default: load_ext_c = i_mem_rdata;
        endcase
    end

    // Read-modify-write merge: only the addressed lane is replaced
    always_comb begin
        merged_c = i_mem_rdata;
        if (size_q == SZ_B) begin
            case (lane_q)
                2'd0:    merged_c[7:0]   = store_lo[7:0];
                2'd1:    merged_c[15:8]  = store_lo[7:0];
                2'd2:    merged_c[23:16] = store_lo[7:0];
                default: merged_c[31:24] = store_lo[7:0];
            endcase
        end else if (lane_q[1]) begin
            merged_c[31:16] = store_lo;
        end else begin
            merged_c[15:0] = store_lo;
        end
    end

    // Registered outputs follow the next state so strobes are pure state decodes
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_ready      <= 1'b1;
            o_valid      <= 1'b0;
            o_misaligned <= 1'b0;
            o_mem_re     <= 1'b0;
            o_mem_we     <= 1'b0;
            o_rdata      <= '0;
            o_mem_addr   <= '0;
            o_mem_wdata  <= '0;
            op_store     <= 1'b0;
            size_q       <= 2'b00;
            signed_q     <= 1'b0;
            lane_q       <= 2'b00;
            store_lo     <= 16'h0;
        end else begin
            o_ready      <= (state_n == IDLE);
            o_valid      <= (state_n == DONE) || (state_n == ERR);
            o_misaligned <= (state_n == ERR);
            o_mem_re     <= (state_n == RD);
            o_mem_we     <= (state_n == WR);
            if (accept_c) begin
                op_store   <= is_store_c;
                size_q     <= in_size_c;
                signed_q   <= i_size_control[2];
                lane_q     <= i_addr[1:0];
                store_lo   <= i_wdata[15:0];
                o_mem_addr <= i_addr[WORD_ADDR_W+1:2];
                if (is_store_c)
                    o_mem_wdata <= i_wdata;
            end
            if (state == CAP) begin
                if (op_store)
                    o_mem_wdata <= merged_c;
                else
                    o_rdata <= load_ext_c;
            end
        end
    end

endmodule
